// File: rtl/dec8b10b_lanes.sv
// dec8b10b_lanes -- multi-symbol 8b/10b receive decoder with running-disparity
// tracking, comma detection and a saturating error counter.
//
// Ports:
//   BitCLK_10  clock
//   Reset      asynchronous reset, active low
//   rx_valid   rx_data valid this cycle
//   rx_data    NUM_SYM 10b symbols, symbol 0 (earliest) in the low bits;
//              per symbol bit0=a .. bit5=i, bit6=f .. bit9=j
//   err_clr    synchronous clear of err_count (wins over a same-cycle error)
//   out_valid  rx_valid delayed two cycles
//   out_data   decoded bytes, per byte bit0=A .. bit7=H
//   out_k      control-symbol flag per symbol
//   code_err   symbol not in the code table (byte forced to 0)
//   disp_err   running-disparity violation in the symbol
//   comma_det  K28.1 / K28.5 / K28.7 received
//   rd_state   RD after the last valid symbol (0=RD-, 1=RD+)
//   err_count  saturating count of errored symbols
//
// Pipeline: stage 1 registers the raw word; stage 2 decodes it against the
// stored RD and registers every output. Decoded outputs hold on idle cycles.

// One symbol: table decode plus the per-sub-block disparity walk.
module dec8b10b_sym (
   input  logic [9:0] sym,
   input  logic       rd_in,
   output logic [7:0] dec,
   output logic       k,
   output logic       code_err,
   output logic       disp_err,
   output logic       comma,
   output logic       rd_out
);
   // s6/f4 are in transmission order (a / f as MSB) so case items read
   // exactly like the code tables.
   logic [5:0] s6;
   logic [3:0] f4, n4;
   logic [4:0] x;
   logic [2:0] yd, yk, c6, c4;
   logic       ok6, okd4, okk4, k28, kx7, alt_n, alt_p, d7_bad, d_ok;
   logic       e6, e4, r6, r4;

   always_comb begin
      s6    = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
      f4    = {sym[6], sym[7], sym[8], sym[9]};
      x     = 5'd0;
      ok6   = 1'b1;
      yd    = 3'd0;
      okd4  = 1'b1;
      yk    = 3'd0;
      okk4  = 1'b1;

      case (s6)
         6'b100111, 6'b011000: x = 5'd0;
         6'b011101, 6'b100010: x = 5'd1;
         6'b101101, 6'b010010: x = 5'd2;
         6'b110001:            x = 5'd3;
         6'b110101, 6'b001010: x = 5'd4;
         6'b101001:            x = 5'd5;
         6'b011001:            x = 5'd6;
         6'b111000, 6'b000111: x = 5'd7;
         6'b111001, 6'b000110: x = 5'd8;
         6'b100101:            x = 5'd9;
         6'b010101:            x = 5'd10;
         6'b110100:            x = 5'd11;
         6'b001101:            x = 5'd12;
         6'b101100:            x = 5'd13;
         6'b011100:            x = 5'd14;
         6'b010111, 6'b101000: x = 5'd15;
         6'b011011, 6'b100100: x = 5'd16;
         6'b100011:            x = 5'd17;
         6'b010011:            x = 5'd18;
         6'b110010:            x = 5'd19;
         6'b001011:            x = 5'd20;
         6'b101010:            x = 5'd21;
         6'b011010:            x = 5'd22;
         6'b111010, 6'b000101: x = 5'd23;
         6'b110011, 6'b001100: x = 5'd24;
         6'b100110:            x = 5'd25;
         6'b010110:            x = 5'd26;
         6'b110110, 6'b001001: x = 5'd27;
         6'b001110:            x = 5'd28;
         6'b101110, 6'b010001: x = 5'd29;
         6'b011110, 6'b100001: x = 5'd30;
         6'b101011, 6'b010100: x = 5'd31;
         default:              ok6 = 1'b0;
      endcase

      case (f4)
         4'b1011, 4'b0100:                   yd = 3'd0;
         4'b1001:                            yd = 3'd1;
         4'b0101:                            yd = 3'd2;
         4'b1100, 4'b0011:                   yd = 3'd3;
         4'b1101, 4'b0010:                   yd = 3'd4;
         4'b1010:                            yd = 3'd5;
         4'b0110:                            yd = 3'd6;
         4'b1110, 4'b0001, 4'b0111, 4'b1000: yd = 3'd7;
         default:                            okd4 = 1'b0;
      endcase

      // K28 4b codes are the complement set after 110000, so fold that
      // case back onto the 001111 column before decoding.
      k28 = (s6 == 6'b001111) || (s6 == 6'b110000);
      n4  = (s6 == 6'b110000) ? ~f4 : f4;
      case (n4)
         4'b0100: yk = 3'd0;
         4'b1001: yk = 3'd1;
         4'b0101: yk = 3'd2;
         4'b0011: yk = 3'd3;
         4'b0010: yk = 3'd4;
         4'b1010: yk = 3'd5;
         4'b0110: yk = 3'd6;
         4'b1000: yk = 3'd7;
         default: okk4 = 1'b0;
      endcase

      // Kx.7 uses the A7 pattern on x = 23/27/29/30.
      kx7 = ok6 && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)) &&
            ((f4 == 4'b1000) || (f4 == 4'b0111));

      // A7 replaces P7 only where P7 would form a run of five:
      // 0111 after x=17/18/20, 1000 after x=11/13/14.
      alt_n  = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
      alt_p  = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
      d7_bad = ((f4 == 4'b0111) && !alt_n) || ((f4 == 4'b1000) && !alt_p) ||
               ((f4 == 4'b1110) &&  alt_n) || ((f4 == 4'b0001) &&  alt_p);
      d_ok   = ok6 && okd4 && !d7_bad;

      dec      = 8'd0;
      k        = 1'b0;
      comma    = 1'b0;
      code_err = 1'b0;
      if (k28 && okk4) begin
         dec   = {yk, 5'd28};
         k     = 1'b1;
         comma = (yk == 3'd1) || (yk == 3'd5) || (yk == 3'd7);
      end else if (kx7) begin
         dec = {3'd7, x};
         k   = 1'b1;
      end else if (d_ok) begin
         dec = {yd, x};
      end else begin
         code_err = 1'b1;
      end

      // Disparity walk: 6b sub-block first, 4b sees the RD it leaves.
      // On a violation RD resyncs to what the received sub-block implies.
      c6 = 3'd0;
      for (int i = 0; i < 6; i++) c6 = c6 + {2'b00, s6[i]};
      c4 = 3'd0;
      for (int i = 0; i < 4; i++) c4 = c4 + {2'b00, f4[i]};

      e6 = ((c6 > 3'd3) && rd_in) || ((c6 < 3'd3) && !rd_in) ||
           ((s6 == 6'b000111) && !rd_in) || ((s6 == 6'b111000) && rd_in);
      r6 = (c6 > 3'd3) ? 1'b1 : (c6 < 3'd3) ? 1'b0 :
           (s6 == 6'b000111) ? 1'b1 : (s6 == 6'b111000) ? 1'b0 : rd_in;
      e4 = ((c4 > 3'd2) && r6) || ((c4 < 3'd2) && !r6) ||
           ((f4 == 4'b0011) && !r6) || ((f4 == 4'b1100) && r6);
      r4 = (c4 > 3'd2) ? 1'b1 : (c4 < 3'd2) ? 1'b0 :
           (f4 == 4'b0011) ? 1'b1 : (f4 == 4'b1100) ? 1'b0 : r6;

      // A code-errored symbol is transparent to RD.
      disp_err = !code_err && (e6 || e4);
      rd_out   = code_err ? rd_in : r4;
   end
endmodule

module dec8b10b_lanes #(
   parameter int NUM_SYM   = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   BitCLK_10,
   input  logic                   Reset,
   input  logic                   rx_valid,
   input  logic [10*NUM_SYM-1:0]  rx_data,
   input  logic                   err_clr,
   output logic                   out_valid,
   output logic [8*NUM_SYM-1:0]   out_data,
   output logic [NUM_SYM-1:0]     out_k,
   output logic [NUM_SYM-1:0]     code_err,
   output logic [NUM_SYM-1:0]     disp_err,
   output logic [NUM_SYM-1:0]     comma_det,
   output logic                   rd_state,
   output logic [ERR_CNT_W-1:0]   err_count
);
   localparam int STAGES = 2;

   logic [STAGES:1]              vld_pipe;
   logic [10*NUM_SYM-1:0]        s1_data;
   logic [NUM_SYM:0]             rd_chain;
   logic [NUM_SYM-1:0][7:0]      dec_w;
   logic [NUM_SYM-1:0]           k_w, ce_w, de_w, cm_w;
   logic [ERR_CNT_W:0]           err_sum;

   // RD ripples lane to lane: symbol i sees the RD left by symbol i-1.
   assign rd_chain[0] = rd_state;

   for (genvar g = 0; g < NUM_SYM; g++) begin : g_sym
      dec8b10b_sym u_sym (
         .sym      (s1_data[g*10 +: 10]),
         .rd_in    (rd_chain[g]),
         .dec      (dec_w[g]),
         .k        (k_w[g]),
         .code_err (ce_w[g]),
         .disp_err (de_w[g]),
         .comma    (cm_w[g]),
         .rd_out   (rd_chain[g+1])
      );
   end

   // One extra bit of headroom so the saturation test sees the carry.
   always_comb begin
      err_sum = {1'b0, err_count};
      for (int i = 0; i < NUM_SYM; i++)
         err_sum = err_sum + (ERR_CNT_W+1)'(ce_w[i] | de_w[i]);
      if (err_sum > {1'b0, {ERR_CNT_W{1'b1}}})
         err_sum = {1'b0, {ERR_CNT_W{1'b1}}};
   end

   assign out_valid = vld_pipe[STAGES];

   always_ff @(posedge BitCLK_10 or negedge Reset) begin
      if (!Reset) begin
         vld_pipe  <= '0;
         s1_data   <= '0;
         out_data  <= '0;
         out_k     <= '0;
         code_err  <= '0;
         disp_err  <= '0;
         comma_det <= '0;
         rd_state  <= 1'b0;
         err_count <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], rx_valid};
         s1_data  <= rx_data;
         if (vld_pipe[1]) begin
            out_data  <= dec_w;
            out_k     <= k_w;
            code_err  <= ce_w;
            disp_err  <= de_w;
            comma_det <= cm_w;
            rd_state  <= rd_chain[NUM_SYM];
         end
         if (err_clr)
            err_count <= '0;
         else if (vld_pipe[1])
            err_count <= err_sum[ERR_CNT_W-1:0];
      end
   end
endmodule

// File: tb/tb_dec8b10b_lanes.sv
// Directed bench for dec8b10b_lanes (NUM_SYM=2, ERR_CNT_W=8). Expected
// results are pushed to a queue as each word is driven and popped when
// out_valid rises; out_valid itself is checked every cycle against the
// driven rx_valid history.
module tb_dec8b10b_lanes;
   logic        BitCLK_10 = 1'b0;
   logic        Reset     = 1'b0;
   logic        rx_valid  = 1'b0;
   logic [19:0] rx_data   = '0;
   logic        err_clr   = 1'b0;
   logic        out_valid;
   logic [15:0] out_data;
   logic [1:0]  out_k, code_err, disp_err, comma_det;
   logic        rd_state;
   logic [7:0]  err_count;

   always #5 BitCLK_10 = ~BitCLK_10;

   dec8b10b_lanes #(.NUM_SYM(2), .ERR_CNT_W(8)) dut (
      .BitCLK_10 (BitCLK_10),
      .Reset     (Reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .err_clr   (err_clr),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_k     (out_k),
      .code_err  (code_err),
      .disp_err  (disp_err),
      .comma_det (comma_det),
      .rd_state  (rd_state),
      .err_count (err_count)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  k;
      logic [1:0]  ce;
      logic [1:0]  de;
      logic [1:0]  cm;
      logic        rd;
      logic [7:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   exp_cnt = 0;
   logic h1      = 1'b0;   // rx_valid as captured by stage 1

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      logic ev;
      @(posedge BitCLK_10); #1;
      ev = h1;
      h1 = rx_valid;
      chk("out_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL sb_underflow: got empty queue, want pending entry");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data",  32'(out_data),  32'(e.data));
            chk("out_k",     32'(out_k),     32'(e.k));
            chk("code_err",  32'(code_err),  32'(e.ce));
            chk("disp_err",  32'(disp_err),  32'(e.de));
            chk("comma_det", 32'(comma_det), 32'(e.cm));
            chk("rd_state",  32'(rd_state),  32'(e.rd));
            chk("err_count", 32'(err_count), 32'(e.cnt));
         end
      end
   endtask

   task automatic idle();
      rx_valid = 1'b0;
      rx_data  = 20'($urandom);
      tick();
   endtask

   // clr=1 raises err_clr in the cycle the word reaches stage 2.
   task automatic send(input logic [19:0] d, input logic [15:0] data, input logic [1:0] k,
                       input logic [1:0] ce, input logic [1:0] de, input logic [1:0] cm,
                       input logic rd, input bit clr);
      exp_t e;
      int   nerr;
      nerr    = int'(ce[0] | de[0]) + int'(ce[1] | de[1]);
      exp_cnt = clr ? 0 : ((exp_cnt + nerr > 255) ? 255 : exp_cnt + nerr);
      e       = '{data, k, ce, de, cm, rd, 8'(exp_cnt)};
      sb.push_back(e);
      rx_valid = 1'b1;
      rx_data  = d;
      tick();
      if (clr) begin
         err_clr  = 1'b1;
         rx_valid = 1'b0;
         rx_data  = 20'($urandom);
         tick();
         err_clr  = 1'b0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_data"},  32'(out_data),  32'd0);
      chk({tag, "_out_k"},     32'(out_k),     32'd0);
      chk({tag, "_code_err"},  32'(code_err),  32'd0);
      chk({tag, "_disp_err"},  32'(disp_err),  32'd0);
      chk({tag, "_comma"},     32'(comma_det), 32'd0);
      chk({tag, "_rd_state"},  32'(rd_state),  32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge BitCLK_10);
      #1;
      chk_zero("reset");
      @(negedge BitCLK_10);
      Reset = 1'b1;
      h1    = 1'b0;

      // D21.5 + K28.5(RD-) from RD-
      send({10'h155, 10'h17C}, 16'hB5BC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 0);

      // Alternating K28.5 stream from RD+: 0x283 then 0x17C, every word ends RD+
      for (int i = 0; i < 100; i++)
         send({10'h17C, 10'h283}, 16'hBCBC, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 0);

      // Back to RD-
      send({10'h155, 10'h283}, 16'hB5BC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 0);

      // K28.5(RD+) twice from RD-: both violate since the first resyncs to RD-
      send({10'h283, 10'h283}, 16'hBCBC, 2'b11, 2'b00, 2'b11, 2'b11, 1'b0, 0);
      // Violation on symbol 0 only; symbol 1 decodes against the resynced RD-
      send({10'h17C, 10'h283}, 16'hBCBC, 2'b11, 2'b00, 2'b01, 2'b11, 1'b1, 0);

      // RD+ -> RD-, then D0.0 in lane 0 and an invalid symbol in lane 1
      send({10'h155, 10'h283}, 16'hB5BC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 0);
      send({10'h000, 10'h0B9}, 16'h0000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 0);
      // K23.7 and K28.7 (comma) from RD-
      send({10'h07C, 10'h057}, 16'hFCF7, 2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 0);
      // D17.A7 is legal from RD-, D17.P7 in its RD- form is not
      send({10'h1F1, 10'h3B1}, 16'h00F1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b1, 0);
      idle();
      idle();

      // Plain clear on an idle cycle
      err_clr = 1'b1;
      idle();
      err_clr = 1'b0;
      exp_cnt = 0;
      chk("err_clr_idle", 32'(err_count), 32'd0);

      // 260 errored symbols from RD+: counter saturates at 255
      for (int i = 0; i < 130; i++)
         send({10'h000, 10'h000}, 16'h0000, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 0);
      // Errors plus simultaneous err_clr -> 0; D0.0(RD-) from RD+ is a disparity error
      send({10'h000, 10'h0B9}, 16'h0000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1);

      // Valid gaps 1-0-0-1: outputs and RD hold, garbage on rx_data ignored
      send({10'h155, 10'h17C}, 16'hB5BC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 0);
      idle();
      idle();
      chk("hold_data", 32'(out_data), 32'h0000B5BC);
      chk("hold_k",    32'(out_k),    32'd1);
      chk("hold_rd",   32'(rd_state), 32'd1);
      send({10'h155, 10'h283}, 16'hB5BC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 0);
      idle();
      idle();

      // Mid-stream reset: leave RD+, put a word in flight, then reset
      send({10'h155, 10'h17C}, 16'hB5BC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 0);
      idle();
      idle();
      rx_valid = 1'b1;
      rx_data  = {10'h283, 10'h283};
      @(posedge BitCLK_10);
      #2;
      Reset = 1'b0;
      #1;
      chk_zero("midrst");
      rx_valid = 1'b0;
      sb.delete();
      h1      = 1'b0;
      exp_cnt = 0;
      @(negedge BitCLK_10);
      Reset = 1'b1;
      // First post-reset word must be judged against RD-
      send({10'h155, 10'h17C}, 16'hB5BC, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 0);
      idle();
      idle();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
